// File: rtl/theta_stream.sv
`default_nettype none
// ============================================================================
//  Module   : theta_stream
//  Purpose  : Plane-serial Keccak theta step for a folded permutation
//             datapath. Five planes (fixed y, five lanes each) are accepted
//             over a valid/ready stream while the column parities C[x] are
//             accumulated and the planes are buffered. The five
//             theta-transformed planes are then streamed out over a second
//             valid/ready stream. A per-state bypass flag, sampled with the
//             y=0 input beat, passes a state through unchanged.
//
//  Parameters
//    LANE_W       lane width w (1, 2, 4, 8, 16, 32, 64)
//
//  Ports
//    clk          clock, rising edge
//    rst          asynchronous active-high reset
//    in_valid_i   input plane valid
//    in_ready_o   block can accept a plane (LOAD state)
//    in_plane_i   lanes A[x,y], x = 0..4
//    bypass_i     skip theta for this state (sampled on the y=0 beat)
//    out_valid_o  output plane valid (EMIT state)
//    out_ready_i  downstream accepts the plane
//    out_plane_o  lanes A'[x,y], x = 0..4
//    out_y_o      plane index of out_plane_o
//    out_last_o   high with plane y=4
//    busy_o       block holds or is emitting a state
//
//  Revision : 1.0  initial release
// ============================================================================
module theta_stream #(
    parameter int LANE_W = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [4:0][LANE_W-1:0] in_plane_i,
    input  logic                   bypass_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [4:0][LANE_W-1:0] out_plane_o,
    output logic [2:0]             out_y_o,
    output logic                   out_last_o,
    output logic                   busy_o
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    localparam logic [2:0] c_LAST_PLANE = 3'd4;

    state_t                   r_state;
    logic [2:0]               r_cnt;     // plane index being loaded or emitted
    logic                     r_byp;     // bypass flag for the held state
    logic [4:0][LANE_W-1:0]   r_par;     // column parities C[x]
    logic [4:0][LANE_W-1:0]   r_buf [0:4];

    // Plane currently selected for output and the theta column effect D[x]
    logic [4:0][LANE_W-1:0]   w_row;
    logic [4:0][LANE_W-1:0]   w_d;

    // ------------------------------------------------------------------------
    // Handshake and status outputs: decoded from the state register only, so
    // neither ready nor valid has a combinational path from the other side.
    // ------------------------------------------------------------------------
    assign in_ready_o  = (r_state == ST_LOAD);
    assign out_valid_o = (r_state == ST_EMIT);
    assign out_y_o     = r_cnt;
    assign out_last_o  = (r_state == ST_EMIT) && (r_cnt == c_LAST_PLANE);
    assign busy_o      = !((r_state == ST_LOAD) && (r_cnt == 3'd0));

    assign w_row = r_buf[r_cnt];

    // ------------------------------------------------------------------------
    // Theta column effect:
    //   D[x] = C[x-1] ^ rot1(C[x+1]),  rot1(v)[z] = v[z-1 mod w]
    // rot1 is a left rotation by one bit; a one-bit lane rotates onto itself.
    // Output lanes are a single XOR level away from registered buf and C.
    // ------------------------------------------------------------------------
    for (genvar gx = 0; gx < 5; gx++) begin : g_lane
        localparam int c_XM = (gx + 4) % 5;
        localparam int c_XP = (gx + 1) % 5;

        logic [LANE_W-1:0] w_rot;

        if (LANE_W == 1) begin : g_rot_identity
            assign w_rot = r_par[c_XP];
        end else begin : g_rot_left
            assign w_rot = {r_par[c_XP][LANE_W-2:0], r_par[c_XP][LANE_W-1]};
        end

        assign w_d[gx]         = r_par[c_XM] ^ w_rot;
        assign out_plane_o[gx] = r_byp ? w_row[gx] : (w_row[gx] ^ w_d[gx]);
    end

    // ------------------------------------------------------------------------
    // Control and storage
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_LOAD;
            r_cnt   <= 3'd0;
            r_byp   <= 1'b0;
            r_par   <= '0;
            for (int i = 0; i < 5; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (in_valid_i) begin
                        r_buf[r_cnt] <= in_plane_i;
                        for (int x = 0; x < 5; x++) begin
                            r_par[x] <= r_par[x] ^ in_plane_i[x];
                        end
                        // Bypass belongs to the whole state; later beats
                        // do not alter it.
                        if (r_cnt == 3'd0) begin
                            r_byp <= bypass_i;
                        end
                        if (r_cnt == c_LAST_PLANE) begin
                            r_cnt   <= 3'd0;
                            r_state <= ST_EMIT;
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                end

                ST_EMIT: begin
                    if (out_ready_i) begin
                        if (r_cnt == c_LAST_PLANE) begin
                            // Parities are cleared here so the next state
                            // starts accumulating from zero.
                            r_cnt   <= 3'd0;
                            r_par   <= '0;
                            r_state <= ST_LOAD;
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_LOAD;
                    r_cnt   <= 3'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_theta_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_theta_stream
//  Purpose  : Self-checking bench for theta_stream. Three instances
//             (LANE_W = 1, 8, 64) run in lockstep on the same stimulus; the
//             narrower ones see the low bits of each lane. A behavioural
//             theta model computes the expected output planes per width.
//  Revision : 1.0  initial release
// ============================================================================
module tb_theta_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic bypass = 1'b0;
    logic out_ready = 1'b0;
    logic [4:0][63:0] in_plane = '0;

    logic [4:0][0:0]  in1;
    logic [4:0][7:0]  in8;
    logic [4:0][0:0]  p1;
    logic [4:0][7:0]  p8;
    logic [4:0][63:0] p64;

    logic       rdy [3];
    logic       vld [3];
    logic       lst [3];
    logic       bsy [3];
    logic [2:0] oy  [3];

    logic [4:0][63:0] o_pl [3];

    always_comb begin
        for (int x = 0; x < 5; x++) begin
            in1[x]     = in_plane[x][0:0];
            in8[x]     = in_plane[x][7:0];
            o_pl[0][x] = {63'd0, p1[x]};
            o_pl[1][x] = {56'd0, p8[x]};
            o_pl[2][x] = p64[x];
        end
    end

    theta_stream #(.LANE_W(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy[0]),
        .in_plane_i(in1), .bypass_i(bypass), .out_valid_o(vld[0]),
        .out_ready_i(out_ready), .out_plane_o(p1), .out_y_o(oy[0]),
        .out_last_o(lst[0]), .busy_o(bsy[0]));

    theta_stream #(.LANE_W(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy[1]),
        .in_plane_i(in8), .bypass_i(bypass), .out_valid_o(vld[1]),
        .out_ready_i(out_ready), .out_plane_o(p8), .out_y_o(oy[1]),
        .out_last_o(lst[1]), .busy_o(bsy[1]));

    theta_stream #(.LANE_W(64)) u_w64 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy[2]),
        .in_plane_i(in_plane), .bypass_i(bypass), .out_valid_o(vld[2]),
        .out_ready_i(out_ready), .out_plane_o(p64), .out_y_o(oy[2]),
        .out_last_o(lst[2]), .busy_o(bsy[2]));

    // ------------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------------
    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [4:0][63:0] pl;
        logic             byp;
    } beat_t;
    beat_t stim [$];

    // Model: a state is five collected planes, then five expected planes.
    bit               m_load = 1'b1;
    int               n_in   = 0;
    int               n_out  = 0;
    logic [4:0][63:0] m_in [5];
    logic             m_byp  = 1'b0;
    logic [4:0][63:0] exp_out [3][5];
    logic [4:0][63:0] cap     [3][5];
    int               states_done = 0;
    bit               acc_in = 1'b0;
    bit               prev_stall = 1'b0;
    logic [4:0][63:0] prev_pl [3];
    logic [2:0]       prev_y  [3];

    function automatic int wd(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 8 : 64);
    endfunction

    function automatic logic [63:0] lmask(input int w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] rot1(input logic [63:0] v, input int w);
        return ((v << 1) | (v >> (w - 1))) & lmask(w);
    endfunction

    function automatic logic [4:0][63:0] rand_plane();
        logic [4:0][63:0] p;
        for (int x = 0; x < 5; x++) p[x] = {$urandom, $urandom};
        return p;
    endfunction

    task automatic check(input string nm, input int d,
                         input logic [319:0] act, input logic [319:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (w=%0d) t=%0t: got %h, want %h",
                     nm, wd(d), $time, act, exp);
        end
    endtask

    // Software theta over the five collected planes, for every width.
    function automatic void build_expect();
        logic [63:0] c [5];
        logic [63:0] dd [5];
        logic [63:0] mk;
        int w;
        for (int d = 0; d < 3; d++) begin
            w  = wd(d);
            mk = lmask(w);
            for (int x = 0; x < 5; x++) begin
                c[x] = 64'd0;
                for (int y = 0; y < 5; y++) c[x] = c[x] ^ (m_in[y][x] & mk);
            end
            for (int x = 0; x < 5; x++)
                dd[x] = c[(x + 4) % 5] ^ rot1(c[(x + 1) % 5], w);
            for (int y = 0; y < 5; y++)
                for (int x = 0; x < 5; x++)
                    exp_out[d][y][x] = (m_in[y][x] & mk) ^ (m_byp ? 64'd0 : dd[x]);
        end
    endfunction

    // ------------------------------------------------------------------------
    // Compare process: checks every DUT output each cycle, then advances the
    // model with the handshakes that will complete at the next rising edge.
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        acc_in = 1'b0;
        if (rst) begin
            m_load = 1'b1; n_in = 0; n_out = 0; prev_stall = 1'b0;
            for (int d = 0; d < 3; d++) begin
                check("rst_in_ready",  d, rdy[d], 1);
                check("rst_out_valid", d, vld[d], 0);
                check("rst_out_y",     d, oy[d],  0);
                check("rst_out_last",  d, lst[d], 0);
                check("rst_busy",      d, bsy[d], 0);
                check("rst_out_plane", d, o_pl[d], 0);
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                check("in_ready",  d, rdy[d], m_load);
                check("out_valid", d, vld[d], !m_load);
                check("busy",      d, bsy[d], !(m_load && n_in == 0));
                if (!m_load) begin
                    check("out_plane", d, o_pl[d], exp_out[d][n_out]);
                    check("out_y",     d, oy[d], n_out);
                    check("out_last",  d, lst[d], (n_out == 4));
                end
                if (prev_stall) begin
                    check("stall_plane", d, o_pl[d], prev_pl[d]);
                    check("stall_y",     d, oy[d], prev_y[d]);
                end
                prev_pl[d] = o_pl[d];
                prev_y[d]  = oy[d];
            end
            prev_stall = !m_load && !out_ready;

            if (m_load && in_valid) begin
                acc_in = 1'b1;
                m_in[n_in] = in_plane;
                if (n_in == 0) m_byp = bypass;
                n_in++;
                if (n_in == 5) begin
                    build_expect();
                    m_load = 1'b0; n_in = 0; n_out = 0;
                end
            end else if (!m_load && out_ready) begin
                for (int d = 0; d < 3; d++) cap[d][n_out] = o_pl[d];
                n_out++;
                if (n_out == 5) begin
                    m_load = 1'b1; n_out = 0;
                    states_done++;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic send(input logic [4:0][63:0] st [5], input logic b0,
                        input bit rand_rest);
        beat_t b;
        for (int y = 0; y < 5; y++) begin
            b.pl  = st[y];
            b.byp = (y == 0) ? b0 : (rand_rest ? 1'($urandom) : 1'b0);
            stim.push_back(b);
        end
    endtask

    // Drives until n more states have been emitted, or (stop_nin > 0) until
    // stop_nin planes of a state are held.
    task automatic run(input int n, input int gap, input int stall,
                       input int stop_nin);
        int target = states_done + n;
        int cyc = 0;
        bit done = 1'b0;
        while (!done && cyc < 3000) begin
            @(posedge clk); #1;
            if (acc_in && stim.size() > 0) void'(stim.pop_front());
            if (stim.size() > 0 && $urandom_range(99) >= gap) begin
                in_valid = 1'b1;
                in_plane = stim[0].pl;
                bypass   = stim[0].byp;
            end else begin
                in_valid = 1'b0;
                in_plane = rand_plane();
                bypass   = 1'($urandom);
            end
            out_ready = ($urandom_range(99) >= stall);
            cyc++;
            done = (stop_nin > 0) ? (m_load && n_in >= stop_nin)
                                  : (states_done >= target);
        end
        if (!done) begin
            n_fail++;
            $display("FAIL run_timeout: got %0d states, want %0d", states_done, target);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 1'b0;
        stim.delete();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------------
    initial begin
        logic [4:0][63:0] st [5];
        logic [4:0][63:0] e;
        logic [63:0]      msb;
        msb = 64'h8000_0000_0000_0000;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // All-zero state
        for (int y = 0; y < 5; y++) st[y] = '0;
        send(st, 1'b0, 1'b0);
        run(1, 0, 0, 0);
        for (int y = 0; y < 5; y++) check("zero_state", 2, cap[2][y], 0);

        // Single bit at A[0,0]
        for (int y = 0; y < 5; y++) st[y] = '0;
        st[0][0] = 64'h1;
        send(st, 1'b0, 1'b0);
        run(1, 20, 20, 0);
        for (int y = 0; y < 5; y++) begin
            e = '0; e[1] = 64'h1; e[4] = 64'h2;
            if (y == 0) e[0] = 64'h1;
            check("single_bit", 2, cap[2][y], e);
        end

        // Rotation wrap-around at A[1,2], 64-bit lanes
        for (int y = 0; y < 5; y++) st[y] = '0;
        st[2][1] = msb;
        send(st, 1'b0, 1'b0);
        run(1, 20, 20, 0);
        for (int y = 0; y < 5; y++) begin
            e = '0; e[0] = 64'h1; e[2] = msb;
            if (y == 2) e[1] = msb;
            check("wrap_w64", 2, cap[2][y], e);
        end

        // Rotation on one-bit lanes: A[1,2] = 1
        for (int y = 0; y < 5; y++) st[y] = '0;
        st[2][1] = 64'h1;
        send(st, 1'b0, 1'b0);
        run(1, 0, 30, 0);
        for (int y = 0; y < 5; y++) begin
            check("wrap_w1_lane0", 0, cap[0][y][0], 1);
            check("wrap_w1_lane2", 0, cap[0][y][2], 1);
        end
        check("wrap_w1_y2_lane1", 0, cap[0][2][1], 1);

        // Bypass state, then a normal state
        for (int y = 0; y < 5; y++) st[y] = rand_plane();
        send(st, 1'b1, 1'b0);
        run(1, 25, 25, 0);
        for (int y = 0; y < 5; y++) check("bypass_passthru", 2, cap[2][y], st[y]);
        for (int y = 0; y < 5; y++) st[y] = rand_plane();
        send(st, 1'b0, 1'b0);
        run(1, 25, 25, 0);

        // Random states with gaps and stalls
        for (int s = 0; s < 25; s++) begin
            for (int y = 0; y < 5; y++) st[y] = rand_plane();
            send(st, ($urandom_range(9) == 0), 1'b1);
        end
        run(25, 30, 40, 0);

        // Reset after three planes, then a fresh state
        for (int y = 0; y < 5; y++) st[y] = rand_plane();
        send(st, 1'b0, 1'b0);
        run(0, 20, 0, 3);
        pulse_reset();
        for (int y = 0; y < 5; y++) st[y] = rand_plane();
        send(st, 1'b0, 1'b0);
        run(1, 20, 20, 0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
